// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi
// Multi-channel hobby-servo PWM generator sharing one frame counter.
// Each channel keeps a target pulse width (pw_reg) that can be stepped up or
// down once every STEP_DIV frames, or loaded directly. The width is only
// sampled into the active copy (pw_act) at the start of a frame, so no
// frame is ever cut short or stretched.
//
// Ports:
//   CLK          rising-edge clock
//   RST          synchronous active-high reset
//   EN           global run enable; low holds the frame and forces outputs low
//   DIR          per-channel direction, 2 bits each (01 up, 10 down, else hold)
//   LOAD         per-channel direct-load strobe
//   LOAD_VAL     per-channel load value, PW_W bits each
//   SERVO        registered PWM outputs
//   PULSE_WIDTH  current target width per channel
//   LIMIT_MIN    target width sits at MIN_PW
//   LIMIT_MAX    target width sits at MAX_PW
//   FRAME_START  one-cycle pulse at the start of every frame
module servo_pwm_multi #(
  parameter int N_CH     = 2,
  parameter int PW_W     = 16,
  parameter int MIN_PW   = 50,
  parameter int MAX_PW   = 250,
  parameter int INIT_PW  = 150,
  parameter int PERIOD   = 2250,
  parameter int STEP     = 1,
  parameter int STEP_DIV = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic [2*N_CH-1:0]      DIR,
  input  logic [N_CH-1:0]        LOAD,
  input  logic [PW_W*N_CH-1:0]   LOAD_VAL,
  output logic [N_CH-1:0]        SERVO,
  output logic [PW_W*N_CH-1:0]   PULSE_WIDTH,
  output logic [N_CH-1:0]        LIMIT_MIN,
  output logic [N_CH-1:0]        LIMIT_MAX,
  output logic                   FRAME_START
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PW_W-1:0]  L_MIN    = PW_W'(MIN_PW);
  localparam logic [PW_W-1:0]  L_MAX    = PW_W'(MAX_PW);
  localparam logic [PW_W-1:0]  L_INIT   = PW_W'(INIT_PW);
  localparam logic [PW_W-1:0]  L_PER_M1 = PW_W'(PERIOD - 1);
  localparam logic [PW_W-1:0]  L_STEP   = PW_W'(STEP);
  localparam logic [PW_W:0]    L_STEP_X = (PW_W+1)'(STEP);
  localparam logic [DIV_W-1:0] L_DIV_M1 = DIV_W'(STEP_DIV - 1);

  logic [PW_W-1:0]  r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [PW_W-1:0]  r_pw  [N_CH];
  logic [PW_W-1:0]  r_act [N_CH];
  logic [N_CH-1:0]  r_servo;
  logic             r_frame_start;

  logic             w_cnt_zero;
  logic             w_cnt_last;
  logic             w_tick;
  logic [PW_W-1:0]  w_pw_nxt  [N_CH];
  logic [PW_W-1:0]  w_act_eff [N_CH];

  // Step up, saturating at MAX_PW; one extra bit keeps the sum from wrapping.
  function automatic logic [PW_W-1:0] f_inc(input logic [PW_W-1:0] pw);
    logic [PW_W:0] sum;
    sum = {1'b0, pw} + L_STEP_X;
    if (sum > {1'b0, L_MAX}) begin
      f_inc = L_MAX;
    end else begin
      f_inc = sum[PW_W-1:0];
    end
  endfunction

  // Step down, saturating at MIN_PW without ever going below zero.
  function automatic logic [PW_W-1:0] f_dec(input logic [PW_W-1:0] pw);
    if ({1'b0, pw} < ({1'b0, L_MIN} + L_STEP_X)) begin
      f_dec = L_MIN;
    end else begin
      f_dec = pw - L_STEP;
    end
  endfunction

  // Clamp a direct-load value into the legal pulse range.
  function automatic logic [PW_W-1:0] f_clamp(input logic [PW_W-1:0] v);
    if (v < L_MIN) begin
      f_clamp = L_MIN;
    end else if (v > L_MAX) begin
      f_clamp = L_MAX;
    end else begin
      f_clamp = v;
    end
  endfunction

  assign w_cnt_zero = (r_cnt == {PW_W{1'b0}});
  assign w_cnt_last = (r_cnt == L_PER_M1);
  assign w_tick     = EN && w_cnt_last && (r_div == L_DIV_M1);

  // Next target width per channel: load beats a step tick.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_pw_nxt[i] = r_pw[i];
      if (LOAD[i]) begin
        w_pw_nxt[i] = f_clamp(LOAD_VAL[PW_W*i +: PW_W]);
      end else if (w_tick) begin
        case (DIR[2*i +: 2])
          2'b01:   w_pw_nxt[i] = f_inc(r_pw[i]);
          2'b10:   w_pw_nxt[i] = f_dec(r_pw[i]);
          default: w_pw_nxt[i] = r_pw[i];
        endcase
      end else begin
        w_pw_nxt[i] = r_pw[i];
      end
    end
  end

  // At count 0 the active width is being reloaded this very edge, so the
  // comparison uses pw_reg directly; that keeps the high time exactly pw_act.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      if (w_cnt_zero) begin
        w_act_eff[i] = r_pw[i];
      end else begin
        w_act_eff[i] = r_act[i];
      end
    end
  end

  // Frame counter, frame divider, width registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt         <= {PW_W{1'b0}};
      r_div         <= {DIV_W{1'b0}};
      r_servo       <= {N_CH{1'b0}};
      r_frame_start <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_pw[i]  <= L_INIT;
        r_act[i] <= L_INIT;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_pw[i] <= w_pw_nxt[i];
      end
      if (EN) begin
        r_cnt <= w_cnt_last ? {PW_W{1'b0}} : r_cnt + PW_W'(1);
        if (w_cnt_last) begin
          r_div <= (r_div == L_DIV_M1) ? {DIV_W{1'b0}} : r_div + DIV_W'(1);
        end
        r_frame_start <= w_cnt_zero;
        for (int i = 0; i < N_CH; i++) begin
          if (w_cnt_zero) begin
            r_act[i] <= r_pw[i];
          end
          r_servo[i] <= (r_cnt < w_act_eff[i]);
        end
      end else begin
        // Disabled: park at the start of a frame; any partial frame is dropped.
        r_cnt         <= {PW_W{1'b0}};
        r_div         <= {DIV_W{1'b0}};
        r_servo       <= {N_CH{1'b0}};
        r_frame_start <= 1'b0;
      end
    end
  end

  assign SERVO       = r_servo;
  assign FRAME_START = r_frame_start;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_status
      assign PULSE_WIDTH[PW_W*g +: PW_W] = r_pw[g];
      assign LIMIT_MIN[g] = (r_pw[g] == L_MIN);
      assign LIMIT_MAX[g] = (r_pw[g] == L_MAX);
    end
  endgenerate

endmodule

// File: doc/servo_pwm_multi.md
SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent servo channels (1..16).
REQ-002 SHALL have parameter PW_W, default 16: pulse-width and frame counter width in bits.
REQ-003 SHALL have parameter MIN_PW, default 50: minimum pulse width in CLK cycles.
REQ-004 SHALL have parameter MAX_PW, default 250: maximum pulse width in CLK cycles; MIN_PW < MAX_PW < PERIOD.
REQ-005 SHALL have parameter INIT_PW, default 150: pulse width loaded at reset.
REQ-006 SHALL have parameter PERIOD, default 2250: frame length in CLK cycles; PERIOD < 2^PW_W.
REQ-007 SHALL have parameter STEP, default 1: pulse-width change per update.
REQ-008 SHALL have parameter STEP_DIV, default 1: number of frames per update (>=1).
REQ-009 SHALL have port CLK, input, 1 bit: single clock; all logic is on the rising edge.
REQ-010 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-011 SHALL have port EN, input, 1 bit: global run enable.
REQ-012 SHALL have port DIR, input, 2*N_CH bits: per-channel direction, DIR[2i+1:2i]; 01 = increase, 10 = decrease, 00/11 = hold.
REQ-013 SHALL have port LOAD, input, N_CH bits: per-channel direct-load strobe, one cycle wide.
REQ-014 SHALL have port LOAD_VAL, input, PW_W*N_CH bits: per-channel load value, slice i at [PW_W*i +: PW_W].
REQ-015 SHALL have port SERVO, output, N_CH bits: registered per-channel PWM outputs.
REQ-016 SHALL have port PULSE_WIDTH, output, PW_W*N_CH bits: current target width per channel (pw_reg).
REQ-017 SHALL have port LIMIT_MIN, output, N_CH bits: high while pw_reg[i] == MIN_PW.
REQ-018 SHALL have port LIMIT_MAX, output, N_CH bits: high while pw_reg[i] == MAX_PW.
REQ-019 SHALL have port FRAME_START, output, 1 bit: one-cycle pulse when the frame counter is at 0 with EN high.

Function
REQ-020 SHALL run one shared frame counter, 0..PERIOD-1, incrementing each cycle while EN=1 and wrapping from PERIOD-1 to 0.
REQ-021 SHALL copy pw_reg[i] into pw_act[i] for all channels when the counter is 0, so that width changes never truncate or extend a frame in progress.
REQ-022 SHALL register SERVO[i] <= (cnt < pw_act[i]), giving one cycle of latency: the high time is exactly pw_act[i] cycles and the low time is PERIOD - pw_act[i] cycles per frame.
REQ-023 SHALL generate an update tick at cnt == PERIOD-1 once every STEP_DIV frames, using a frame-divider counter that wraps at STEP_DIV-1.
REQ-024 SHALL, on a tick with DIR = 01, set pw_reg[i] to min(pw_reg[i] + STEP, MAX_PW), computed without overflow at width PW_W+1.
REQ-025 SHALL, on a tick with DIR = 10, set pw_reg[i] to max(pw_reg[i] - STEP, MIN_PW), with no underflow wrap.
REQ-026 SHALL leave pw_reg[i] unchanged on a tick with DIR = 00 or 11.
REQ-027 SHALL, when LOAD[i] = 1, set pw_reg[i] to LOAD_VAL[i] clamped to [MIN_PW, MAX_PW] in the next cycle; this takes effect regardless of EN.
REQ-028 SHALL give LOAD[i] priority over a DIR update tick in the same cycle, so that the load value wins.
REQ-029 SHALL update each channel independently; one channel's DIR or LOAD has no effect on any other channel.
REQ-030 SHALL, while EN = 0: hold the counter at 0, hold the divider at 0, drive SERVO to 0 and FRAME_START to 0, and retain pw_reg.
REQ-031 SHALL, on EN rising, start frame 0 in the next cycle, loading pw_act as in REQ-021.
REQ-032 SHALL, when EN falls mid-frame, drive SERVO low in the next cycle; the frame is abandoned and not resumed.
REQ-033 SHALL drive LIMIT_MIN, LIMIT_MAX and PULSE_WIDTH combinationally from pw_reg.

Reset
REQ-034 SHALL, while RST = 1, set cnt = 0, divider = 0, SERVO = 0, FRAME_START = 0, pw_reg[i] = INIT_PW and pw_act[i] = INIT_PW for all channels.
REQ-035 SHALL give RST priority over EN, LOAD and DIR; asserting RST mid-frame forces SERVO low in the next cycle.

Verification (defaults: N_CH=2, STEP=1, STEP_DIV=1)
REQ-036 SHALL cover: RST, then EN=1 with DIR=00 -> SERVO[0] high 150 cycles, low 2100 cycles; FRAME_START period = 2250 cycles.
REQ-037 SHALL cover: DIR[1:0]=01 for 3 frames -> PULSE_WIDTH[0] = 151, 152, 153 after successive frame ends; channel 1 stays at 150.
REQ-038 SHALL cover: LOAD[0] with LOAD_VAL = 249, then DIR=01 for 3 frames -> values 250, 250, 250; LIMIT_MAX[0] = 1 from the first tick.
REQ-039 SHALL cover: LOAD_VAL = 10 -> pw_reg = 50 and LIMIT_MIN = 1; LOAD_VAL = 400 -> pw_reg = 250.
REQ-040 SHALL cover: LOAD[0] mid-frame at cnt = 60 with value 200 -> the current frame's high time stays 150; the next frame's high time is 200.
REQ-041 SHALL cover: LOAD coincident with the tick at cnt = 2249 with DIR = 10 -> pw_reg = LOAD_VAL; then EN dropped at cnt = 100 -> SERVO = 0 the next cycle and pw_reg retained.
